// File: rtl/chunk_row_arbiter_pkg.sv
// rtl/chunk_row_arbiter_pkg.sv - shared configuration and FSM encoding for the chunk row arbiter
package TauCfg;

    localparam int GLOBAL_ADDR_BW = 32;
    localparam int DIM            = 2;
    localparam int VSIZE          = 8;
    localparam int NREQ_DEFAULT   = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUE  = 2'd1,
        ARB_STREAM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/chunk_row_arbiter_picker.sv
// rtl/chunk_row_arbiter_picker.sv - round-robin pick of the first request at or after the pointer
module chunk_row_arbiter_picker #(
    parameter int NREQ = 2,
    parameter int IBW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IBW-1:0]  ptr,
    output logic            any,
    output logic [NREQ-1:0] grant_oh,
    output logic [IBW-1:0]  grant_idx
);

    logic [IBW-1:0] idx;

    always_comb begin
        any       = 1'b0;
        grant_oh  = '0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IBW'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any           = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/chunk_row_arbiter.sv
// rtl/chunk_row_arbiter.sv - shares one row-start generator among NREQ requesters, one command at a time
module chunk_row_arbiter #(
    parameter int NREQ  = TauCfg::NREQ_DEFAULT,
    parameter int GBW   = TauCfg::GLOBAL_ADDR_BW,
    parameter int DIM   = TauCfg::DIM,
    parameter int VSIZE = TauCfg::VSIZE,
    parameter int V_BW  = $clog2(VSIZE),
    parameter int IBW   = $clog2(NREQ)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [NREQ-1:0]                     req_rdy,
    output logic [NREQ-1:0]                     req_ack,
    input  logic [NREQ-1:0][DIM-1:0][GBW-1:0]   i_req_mofs,
    input  logic [NREQ-1:0][DIM-1:0][GBW-1:0]   i_req_mbound,
    input  logic [NREQ-1:0][DIM-1:0][GBW-1:0]   i_req_mlast,
    input  logic [NREQ-1:0][DIM-1:0][V_BW-1:0]  i_req_mpad,
    input  logic [NREQ-1:0][GBW-1:0]            i_req_maddr,
    input  logic [NREQ-1:0]                     i_req_wrap,
    output logic                                mofs_rdy,
    input  logic                                mofs_ack,
    output logic [DIM-1:0][GBW-1:0]             o_mofs,
    output logic [DIM-1:0][GBW-1:0]             o_mbound,
    output logic [DIM-1:0][GBW-1:0]             o_mlast,
    output logic [DIM-1:0][V_BW-1:0]            o_mpad,
    output logic [GBW-1:0]                      o_maddr,
    output logic                                o_wrap,
    input  logic                                row_rdy,
    output logic                                row_ack,
    input  logic                                i_row_islast,
    output logic [NREQ-1:0]                     out_rdy,
    input  logic [NREQ-1:0]                     out_ack,
    output logic [IBW-1:0]                      o_out_id,
    output logic                                o_busy
);

    import TauCfg::*;

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [IBW-1:0]  rr_ptr;
    logic [IBW-1:0]  grant;
    logic            pick_any;
    logic [NREQ-1:0] pick_oh;
    logic [IBW-1:0]  pick_idx;
    logic            take_grant;

    chunk_row_arbiter_picker #(
        .NREQ (NREQ),
        .IBW  (IBW)
    ) u_picker (
        .req       (req_rdy),
        .ptr       (rr_ptr),
        .any       (pick_any),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx)
    );

    assign take_grant = (state == ARB_IDLE) && pick_any;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (pick_any) state_nxt = ARB_ISSUE;
            ARB_ISSUE:  if (mofs_ack) state_nxt = ARB_STREAM;
            ARB_STREAM: if (row_rdy && out_ack[grant] && i_row_islast) state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    // Command fields are captured once at grant so requester churn cannot leak into the issued command.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr   <= '0;
            grant    <= '0;
            o_mofs   <= '0;
            o_mbound <= '0;
            o_mlast  <= '0;
            o_mpad   <= '0;
            o_maddr  <= '0;
            o_wrap   <= 1'b0;
        end else if (take_grant) begin
            rr_ptr   <= (pick_idx == IBW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            grant    <= pick_idx;
            o_mofs   <= i_req_mofs[pick_idx];
            o_mbound <= i_req_mbound[pick_idx];
            o_mlast  <= i_req_mlast[pick_idx];
            o_mpad   <= i_req_mpad[pick_idx];
            o_maddr  <= i_req_maddr[pick_idx];
            o_wrap   <= i_req_wrap[pick_idx];
        end
    end

    // Every handshake output is forced low while reset is held so nothing completes on the reset edge.
    always_comb begin
        req_ack  = '0;
        mofs_rdy = 1'b0;
        row_ack  = 1'b0;
        out_rdy  = '0;
        o_busy   = 1'b0;
        o_out_id = '0;
        if (!i_rst) begin
            case (state)
                ARB_IDLE: begin
                    req_ack = pick_oh;
                end
                ARB_ISSUE: begin
                    mofs_rdy = 1'b1;
                    o_busy   = 1'b1;
                    o_out_id = grant;
                end
                ARB_STREAM: begin
                    out_rdy[grant] = row_rdy;
                    row_ack        = out_ack[grant];
                    o_busy         = 1'b1;
                    o_out_id       = grant;
                end
                default: begin
                    o_busy = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_row_arbiter.sv
// tb/tb_chunk_row_arbiter.sv - self-checking bench for chunk_row_arbiter
module tb_chunk_row_arbiter;

    localparam int NREQ = 2;
    localparam int GBW  = 32;
    localparam int DIM  = 2;
    localparam int V_BW = 3;

    logic                               i_clk = 1'b0;
    logic                               i_rst;
    logic [NREQ-1:0]                    req_rdy;
    logic [NREQ-1:0]                    req_ack;
    logic [NREQ-1:0][DIM-1:0][GBW-1:0]  req_mofs;
    logic [NREQ-1:0][DIM-1:0][GBW-1:0]  req_mbound;
    logic [NREQ-1:0][DIM-1:0][GBW-1:0]  req_mlast;
    logic [NREQ-1:0][DIM-1:0][V_BW-1:0] req_mpad;
    logic [NREQ-1:0][GBW-1:0]           req_maddr;
    logic [NREQ-1:0]                    req_wrap;
    logic                               mofs_rdy;
    logic                               mofs_ack;
    logic [DIM-1:0][GBW-1:0]            o_mofs;
    logic [DIM-1:0][GBW-1:0]            o_mbound;
    logic [DIM-1:0][GBW-1:0]            o_mlast;
    logic [DIM-1:0][V_BW-1:0]           o_mpad;
    logic [GBW-1:0]                     o_maddr;
    logic                               o_wrap;
    logic                               row_rdy;
    logic                               row_ack;
    logic                               row_islast;
    logic [NREQ-1:0]                    out_rdy;
    logic [NREQ-1:0]                    out_ack;
    logic [0:0]                         o_out_id;
    logic                               o_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    chunk_row_arbiter #(
        .NREQ  (NREQ),
        .GBW   (GBW),
        .DIM   (DIM),
        .VSIZE (8)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .req_rdy      (req_rdy),
        .req_ack      (req_ack),
        .i_req_mofs   (req_mofs),
        .i_req_mbound (req_mbound),
        .i_req_mlast  (req_mlast),
        .i_req_mpad   (req_mpad),
        .i_req_maddr  (req_maddr),
        .i_req_wrap   (req_wrap),
        .mofs_rdy     (mofs_rdy),
        .mofs_ack     (mofs_ack),
        .o_mofs       (o_mofs),
        .o_mbound     (o_mbound),
        .o_mlast      (o_mlast),
        .o_mpad       (o_mpad),
        .o_maddr      (o_maddr),
        .o_wrap       (o_wrap),
        .row_rdy      (row_rdy),
        .row_ack      (row_ack),
        .i_row_islast (row_islast),
        .out_rdy      (out_rdy),
        .out_ack      (out_ack),
        .o_out_id     (o_out_id),
        .o_busy       (o_busy)
    );

    // Plays requester/generator/consumer for one command, called at a negedge; returns observations.
    task automatic run_cmd(input int nrows, input int mofs_wait, input int stall_row, input int stall_n,
                           input bit hold, input bit chg, input logic [31:0] chg_val,
                           input bit raise_other, input int abort_at,
                           output int gid, output int lat, output logic [31:0] maddr_seen,
                           output int rows_got, output int viol, output logic busy_after);
        bit got;
        logic [DIM-1:0][GBW-1:0] first_mofs;
        logic [1:0] oh;
        gid = -1; lat = 0; rows_got = 0; viol = 0; busy_after = 1'b1; got = 0; maddr_seen = '0;
        for (int c = 0; c < 50 && !got; c++) begin
            #1;
            if (req_ack != '0) begin
                got = 1;
                gid = req_ack[1] ? 1 : 0;
                if (req_ack == 2'b11) viol++;
            end else begin
                @(negedge i_clk);
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL grant_timeout: observed no req_ack, required a grant within 50 cycles");
            return;
        end
        oh = '0;
        oh[gid[0]] = 1'b1;
        @(negedge i_clk);
        if (!hold) req_rdy[gid[0]] = 1'b0;
        if (chg) req_maddr[gid[0]] = chg_val;
        if (raise_other) req_rdy[~gid[0]] = 1'b1;
        row_rdy = 1'b1; row_islast = (nrows == 1); mofs_ack = 1'b0; out_ack = '0;
        #1;
        lat = 1;
        while (!mofs_rdy && lat < 20) begin
            @(negedge i_clk); #1; lat++;
        end
        maddr_seen = o_maddr;
        first_mofs = o_mofs;
        for (int c = 0; c < mofs_wait; c++) begin
            if (!mofs_rdy || o_maddr !== maddr_seen || o_mofs !== first_mofs || req_ack !== 2'b00 ||
                row_ack !== 1'b0 || out_rdy !== 2'b00 || o_out_id !== gid[0] || o_busy !== 1'b1) viol++;
            @(negedge i_clk); #1;
        end
        mofs_ack = 1'b1;
        @(negedge i_clk);
        mofs_ack = 1'b0;
        for (int r = 0; r < nrows; r++) begin
            if (r == abort_at) return;
            row_rdy = 1'b1; row_islast = (r == nrows - 1); out_ack = '0;
            #1;
            if (r == stall_row) begin
                for (int s = 0; s < stall_n; s++) begin
                    if (row_ack !== 1'b0 || out_rdy !== oh || o_maddr !== maddr_seen) viol++;
                    @(negedge i_clk); #1;
                end
            end
            out_ack[gid[0]] = 1'b1;
            #1;
            if (row_ack === 1'b1) rows_got++;
            if (o_out_id !== gid[0] || req_ack !== 2'b00 || o_maddr !== maddr_seen ||
                out_rdy !== oh || o_busy !== 1'b1) viol++;
            @(negedge i_clk);
        end
        out_ack = '0; row_rdy = 1'b0; row_islast = 1'b0;
        #1;
        busy_after = o_busy;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; req_rdy = 2'b01; row_rdy = 1'b1; out_ack = 2'b11; mofs_ack = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        n_cmp++; if (req_ack !== 2'b00) begin n_err++; $display("FAIL rst_req_ack got %b want 00", req_ack); end
        n_cmp++; if (mofs_rdy !== 1'b0) begin n_err++; $display("FAIL rst_mofs_rdy got %b want 0", mofs_rdy); end
        n_cmp++; if (row_ack !== 1'b0) begin n_err++; $display("FAIL rst_row_ack got %b want 0", row_ack); end
        n_cmp++; if (out_rdy !== 2'b00) begin n_err++; $display("FAIL rst_out_rdy got %b want 00", out_rdy); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", o_busy); end
        n_cmp++; if (o_out_id !== 1'b0) begin n_err++; $display("FAIL rst_out_id got %b want 0", o_out_id); end
        n_cmp++; if (o_maddr !== 32'h0) begin n_err++; $display("FAIL rst_maddr got %h want 0", o_maddr); end
        req_rdy = '0; row_rdy = 1'b0; out_ack = '0; mofs_ack = 1'b0; i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_single();
        int gid, lat, rows, viol; logic [31:0] ma; logic busy;
        req_maddr[0] = 32'h100; req_mofs[0] = {32'h11, 32'h22}; req_rdy = 2'b01;
        run_cmd(3, 0, -1, 0, 0, 0, 32'h0, 0, -1, gid, lat, ma, rows, viol, busy);
        n_cmp++; if (gid !== 0) begin n_err++; $display("FAIL single_gid got %0d want 0", gid); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL single_latency got %0d want 1", lat); end
        n_cmp++; if (ma !== 32'h100) begin n_err++; $display("FAIL single_maddr got %h want 100", ma); end
        n_cmp++; if (rows !== 3) begin n_err++; $display("FAIL single_rows got %0d want 3", rows); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL single_protocol got %0d violations want 0", viol); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after got %b want 0", busy); end
    endtask

    task automatic test_field_hold();
        int gid, lat, rows, viol; logic [31:0] ma; logic busy;
        req_maddr[0] = 32'h100; req_rdy = 2'b01;
        run_cmd(2, 2, -1, 0, 0, 1, 32'h200, 0, -1, gid, lat, ma, rows, viol, busy);
        n_cmp++; if (ma !== 32'h100) begin n_err++; $display("FAIL hold_maddr got %h want 100", ma); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL hold_stable got %0d violations want 0", viol); end
        req_maddr[0] = 32'h100;
    endtask

    task automatic test_issue_stall();
        int gid, lat, rows, viol; logic [31:0] ma; logic busy;
        req_maddr[1] = 32'h300; req_mofs[0] = {32'hA5, 32'h5A}; req_rdy = 2'b01;
        run_cmd(2, 5, -1, 0, 0, 0, 32'h0, 1, -1, gid, lat, ma, rows, viol, busy);
        n_cmp++; if (gid !== 0) begin n_err++; $display("FAIL stall_gid got %0d want 0", gid); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL stall_issue_hold got %0d violations want 0", viol); end
        n_cmp++; if (rows !== 2) begin n_err++; $display("FAIL stall_rows got %0d want 2", rows); end
    endtask

    task automatic test_row_stall();
        int gid, lat, rows, viol; logic [31:0] ma; logic busy;
        run_cmd(3, 0, 1, 4, 0, 0, 32'h0, 0, -1, gid, lat, ma, rows, viol, busy);
        n_cmp++; if (gid !== 1) begin n_err++; $display("FAIL rowstall_gid got %0d want 1", gid); end
        n_cmp++; if (ma !== 32'h300) begin n_err++; $display("FAIL rowstall_maddr got %h want 300", ma); end
        n_cmp++; if (rows !== 3) begin n_err++; $display("FAIL rowstall_rows got %0d want 3", rows); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL rowstall_protocol got %0d violations want 0", viol); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rowstall_busy_after got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int gid, lat, rows, viol; logic [31:0] ma; logic busy;
        i_rst = 1'b1; req_rdy = 2'b11;
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_cmd(1 + k % 2, k, -1, 0, 1, 0, 32'h0, 0, -1, gid, lat, ma, rows, viol, busy);
            n_cmp++; if (gid !== k % 2) begin n_err++; $display("FAIL rr_order_%0d got %0d want %0d", k, gid, k % 2); end
            n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL rr_protocol_%0d got %0d violations want 0", k, viol); end
        end
        req_rdy = '0;
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid_stream();
        int gid, lat, rows, viol; logic [31:0] ma; logic busy;
        req_rdy = 2'b01;
        run_cmd(4, 0, -1, 0, 0, 0, 32'h0, 0, 1, gid, lat, ma, rows, viol, busy);
        n_cmp++; if (rows !== 1) begin n_err++; $display("FAIL midrst_rows_before got %0d want 1", rows); end
        i_rst = 1'b1; out_ack = 2'b11; row_rdy = 1'b1; mofs_ack = 1'b1; req_rdy = 2'b11;
        #1;
        n_cmp++; if ({req_ack, mofs_rdy, row_ack, out_rdy, o_busy, o_out_id} !== 8'h00) begin
            n_err++; $display("FAIL midrst_outputs got %b want 00000000", {req_ack, mofs_rdy, row_ack, out_rdy, o_busy, o_out_id});
        end
        @(negedge i_clk);
        i_rst = 1'b0; out_ack = '0; row_rdy = 1'b0; mofs_ack = 1'b0;
        #1;
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle got busy %b want 0", o_busy); end
        n_cmp++; if (req_ack !== 2'b01) begin n_err++; $display("FAIL midrst_rr_ptr got req_ack %b want 01", req_ack); end
        run_cmd(1, 0, -1, 0, 0, 0, 32'h0, 0, -1, gid, lat, ma, rows, viol, busy);
        n_cmp++; if (gid !== 0) begin n_err++; $display("FAIL midrst_first_gid got %0d want 0", gid); end
        run_cmd(1, 0, -1, 0, 0, 0, 32'h0, 0, -1, gid, lat, ma, rows, viol, busy);
        n_cmp++; if (gid !== 1) begin n_err++; $display("FAIL midrst_second_gid got %0d want 1", gid); end
    endtask

    // Reference: requesters pending as a set, grant = first pending index scanning from the pointer.
    task automatic test_random();
        int gid, lat, rows, viol, nrows, exp_gid, ptr, idx;
        logic [31:0] ma;
        logic busy;
        bit pending [NREQ];
        logic [31:0] maddr_m [NREQ];
        i_rst = 1'b1; req_rdy = '0;
        @(negedge i_clk);
        i_rst = 1'b0;
        ptr = 0;
        for (int p = 0; p < NREQ; p++) pending[p] = 0;
        for (int it = 0; it < 30; it++) begin
            int add;
            add = int'($urandom_range(0, 3));
            if (add == 0) add = 1 << $urandom_range(0, 1);
            for (int p = 0; p < NREQ; p++) begin
                if (add[p] && !pending[p]) begin
                    pending[p] = 1;
                    maddr_m[p] = $urandom;
                    req_maddr[p] = maddr_m[p];
                    req_mofs[p] = {$urandom, $urandom};
                    req_wrap[p] = 1'($urandom_range(0, 1));
                    req_rdy[p] = 1'b1;
                end
            end
            exp_gid = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr + k) % NREQ;
                if (exp_gid < 0 && pending[idx]) exp_gid = idx;
            end
            nrows = int'($urandom_range(1, 4));
            run_cmd(nrows, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    0, 0, 32'h0, 0, -1, gid, lat, ma, rows, viol, busy);
            n_cmp++; if (gid !== exp_gid) begin n_err++; $display("FAIL rand_gid_%0d got %0d want %0d", it, gid, exp_gid); end
            n_cmp++; if (exp_gid >= 0 && ma !== maddr_m[exp_gid]) begin n_err++; $display("FAIL rand_maddr_%0d got %h want %h", it, ma, maddr_m[exp_gid]); end
            n_cmp++; if (rows !== nrows) begin n_err++; $display("FAIL rand_rows_%0d got %0d want %0d", it, rows, nrows); end
            n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rand_latency_%0d got %0d want 1", it, lat); end
            n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL rand_protocol_%0d got %0d violations want 0", it, viol); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand_busy_after_%0d got %b want 0", it, busy); end
            if (exp_gid >= 0) begin
                pending[exp_gid] = 0;
                ptr = (exp_gid + 1) % NREQ;
            end
        end
        req_rdy = '0;
        @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1; req_rdy = '0; req_mofs = '0; req_mbound = '0; req_mlast = '0; req_mpad = '0;
        req_maddr = '0; req_wrap = '0; mofs_ack = 1'b0; row_rdy = 1'b0; row_islast = 1'b0; out_ack = '0;
        @(negedge i_clk);
        test_reset();
        test_single();
        test_field_hold();
        test_issue_stall();
        test_row_stall();
        test_round_robin();
        test_reset_mid_stream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
